ahb_rom_arbiter: RTL and testbench

Two-port AHB-Lite slave front-end that shares one single-port synchronous boot ROM between two masters: instruction fetch on S0 and debug/loader on S1.
- Arbitrates ROM read cycles round-robin and honours HMASTLOCK.
- Inserts wait states for the losing master.
- Returns two-cycle ERROR on writes.
- Sits between the AHB interconnect and the ROM macro; the ROM is clocked on HCLK and returns data one cycle after rom_en.

---
 rtl/ahb_rom_arbiter_pkg.sv | 28 ++
 rtl/ahb_rom_port.sv | 85 ++++++++
 rtl/ahb_rom_arbiter.sv | 96 +++++++++
 tb/tb_ahb_rom_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_rom_arbiter_pkg.sv
// Shared AHB codes, port FSM encoding and the address-phase bundle
// used by the two-master boot ROM front-end.
package ahb_rom_arbiter_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY    = 2'b00;
   localparam logic [1:0] HRESP_ERROR   = 2'b01;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_WAIT = 3'd1;
   localparam logic [2:0] ST_DATA = 3'd2;
   localparam logic [2:0] ST_ERR1 = 3'd3;
   localparam logic [2:0] ST_ERR2 = 3'd4;

   typedef struct packed {
      logic        hsel;
      logic [31:0] haddr;
      logic [1:0]  htrans;
      logic        hwrite;
      logic        hmastlock;
      logic        hready;
   } ahb_req_t;

endpackage

// File: rtl/ahb_rom_port.sv
// One AHB-Lite slave port: accepts reads/writes, holds a losing read until
// granted, and forms the ready/response/data seen by its master.
module ahb_rom_port
   import ahb_rom_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = 15,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  ahb_req_t          req_i,
   input  logic              grant_i,
   input  logic [DATA_W-1:0] rom_data_i,
   output logic              cand_c_o,
   output logic              lock_c_o,
   output logic [ADDR_W-1:0] addr_c_o,
   output logic              hreadyout_o,
   output logic [1:0]        hresp_o,
   output logic [DATA_W-1:0] hrdata_c_o
);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
   logic              pend_lock_q, pend_lock_d;
   logic              hreadyout_d;
   logic [1:0]        hresp_d;
   logic              accept, new_rd, waiting;
   logic              unused_haddr;

   assign unused_haddr = ^{req_i.haddr[31:ADDR_W+2], req_i.haddr[1:0]};

   // A new address phase is only taken while this port is presenting HREADYOUT=1.
   assign accept  = req_i.hsel & req_i.htrans[1] & req_i.hready
                  & ((state_q == ST_IDLE) | (state_q == ST_DATA));
   assign new_rd  = accept & ~req_i.hwrite;
   assign waiting = (state_q == ST_WAIT);

   assign cand_c_o   = new_rd | waiting;
   assign addr_c_o   = waiting ? pend_addr_q : req_i.haddr[ADDR_W+1:2];
   assign lock_c_o   = waiting ? pend_lock_q : req_i.hmastlock;
   assign hrdata_c_o = (state_q == ST_DATA) ? rom_data_i : '0;

   always_comb begin
      state_d     = state_q;
      pend_addr_d = pend_addr_q;
      pend_lock_d = pend_lock_q;
      case (state_q)
         ST_IDLE, ST_DATA: begin
            if (accept && req_i.hwrite) begin
               state_d = ST_ERR1;
            end else if (new_rd) begin
               state_d = grant_i ? ST_DATA : ST_WAIT;
               if (!grant_i) begin
                  pend_addr_d = req_i.haddr[ADDR_W+1:2];
                  pend_lock_d = req_i.hmastlock;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: if (grant_i) state_d = ST_DATA;
         ST_ERR1: state_d = ST_ERR2;
         default: state_d = ST_IDLE;
      endcase
      hreadyout_d = ~((state_d == ST_WAIT) | (state_d == ST_ERR1));
      hresp_d     = ((state_d == ST_ERR1) | (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         pend_addr_q <= '0;
         pend_lock_q <= 1'b0;
         hreadyout_o <= 1'b1;
         hresp_o     <= HRESP_OKAY;
      end else begin
         state_q     <= state_d;
         pend_addr_q <= pend_addr_d;
         pend_lock_q <= pend_lock_d;
         hreadyout_o <= hreadyout_d;
         hresp_o     <= hresp_d;
      end
   end

endmodule

// File: rtl/ahb_rom_arbiter.sv
// Two-master AHB-Lite front-end sharing one synchronous boot ROM:
// round-robin arbitration with HMASTLOCK hold, ROM address mux.
module ahb_rom_arbiter
   import ahb_rom_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = 15,
   parameter int unsigned DATA_W = 32
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              S0_HSEL,
   input  logic [31:0]       S0_HADDR,
   input  logic [1:0]        S0_HTRANS,
   input  logic              S0_HWRITE,
   input  logic              S0_HMASTLOCK,
   input  logic              S0_HREADY,
   output logic              S0_HREADYOUT,
   output logic [1:0]        S0_HRESP,
   output logic [DATA_W-1:0] S0_HRDATA,
   input  logic              S1_HSEL,
   input  logic [31:0]       S1_HADDR,
   input  logic [1:0]        S1_HTRANS,
   input  logic              S1_HWRITE,
   input  logic              S1_HMASTLOCK,
   input  logic              S1_HREADY,
   output logic              S1_HREADYOUT,
   output logic [1:0]        S1_HRESP,
   output logic [DATA_W-1:0] S1_HRDATA,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data
);

   ahb_req_t          s0_req, s1_req;
   logic              cand0, cand1, lock0, lock1, req0, req1, grant0, grant1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic              last_grant_q, last_grant_d;
   logic              last_lock_q, last_lock_d;

   assign s0_req = '{hsel: S0_HSEL, haddr: S0_HADDR, htrans: S0_HTRANS,
                     hwrite: S0_HWRITE, hmastlock: S0_HMASTLOCK, hready: S0_HREADY};
   assign s1_req = '{hsel: S1_HSEL, haddr: S1_HADDR, htrans: S1_HTRANS,
                     hwrite: S1_HWRITE, hmastlock: S1_HMASTLOCK, hready: S1_HREADY};

   ahb_rom_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port0 (
      .clk_i(HCLK), .rst_i(HRESET), .req_i(s0_req), .grant_i(grant0),
      .rom_data_i(rom_data), .cand_c_o(cand0), .lock_c_o(lock0), .addr_c_o(addr0),
      .hreadyout_o(S0_HREADYOUT), .hresp_o(S0_HRESP), .hrdata_c_o(S0_HRDATA)
   );

   ahb_rom_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port1 (
      .clk_i(HCLK), .rst_i(HRESET), .req_i(s1_req), .grant_i(grant1),
      .rom_data_i(rom_data), .cand_c_o(cand1), .lock_c_o(lock1), .addr_c_o(addr1),
      .hreadyout_o(S1_HREADYOUT), .hresp_o(S1_HRESP), .hrdata_c_o(S1_HRDATA)
   );

   // Nothing reaches the ROM while reset is held.
   assign req0 = cand0 & ~HRESET;
   assign req1 = cand1 & ~HRESET;

   // On a tie the lock owner keeps the ROM, otherwise the other port wins.
   always_comb begin
      grant0       = 1'b0;
      grant1       = 1'b0;
      last_grant_d = last_grant_q;
      last_lock_d  = last_lock_q;
      if (req0 && req1) begin
         grant1 = last_lock_q ? last_grant_q : ~last_grant_q;
         grant0 = ~grant1;
      end else begin
         grant0 = req0;
         grant1 = req1;
      end
      if (grant0) begin
         last_grant_d = 1'b0;
         last_lock_d  = lock0;
      end else if (grant1) begin
         last_grant_d = 1'b1;
         last_lock_d  = lock1;
      end
   end

   assign rom_en   = grant0 | grant1;
   assign rom_addr = grant0 ? addr0 : (grant1 ? addr1 : '0);

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         last_grant_q <= 1'b1;
         last_lock_q  <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
         last_lock_q  <= last_lock_d;
      end
   end

endmodule

// File: tb/tb_ahb_rom_arbiter.sv
// Bench for ahb_rom_arbiter: cycle vector table with a per-port read-data
// scoreboard, plus a randomised locked-burst sequence against a waiting port.
module tb_ahb_rom_arbiter;
   import ahb_rom_arbiter_pkg::*;

   localparam int unsigned ADDR_W = 15;
   localparam int unsigned DATA_W = 32;

   logic              HCLK = 1'b0;
   logic              HRESET;
   logic              S0_HSEL, S0_HWRITE, S0_HMASTLOCK, S0_HREADY, S0_HREADYOUT;
   logic [31:0]       S0_HADDR;
   logic [1:0]        S0_HTRANS, S0_HRESP;
   logic [DATA_W-1:0] S0_HRDATA;
   logic              S1_HSEL, S1_HWRITE, S1_HMASTLOCK, S1_HREADY, S1_HREADYOUT;
   logic [31:0]       S1_HADDR;
   logic [1:0]        S1_HTRANS, S1_HRESP;
   logic [DATA_W-1:0] S1_HRDATA;
   logic              rom_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data = '0;

   int checks = 0;
   int errors = 0;

   ahb_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .S0_HSEL(S0_HSEL), .S0_HADDR(S0_HADDR), .S0_HTRANS(S0_HTRANS), .S0_HWRITE(S0_HWRITE),
      .S0_HMASTLOCK(S0_HMASTLOCK), .S0_HREADY(S0_HREADY), .S0_HREADYOUT(S0_HREADYOUT),
      .S0_HRESP(S0_HRESP), .S0_HRDATA(S0_HRDATA),
      .S1_HSEL(S1_HSEL), .S1_HADDR(S1_HADDR), .S1_HTRANS(S1_HTRANS), .S1_HWRITE(S1_HWRITE),
      .S1_HMASTLOCK(S1_HMASTLOCK), .S1_HREADY(S1_HREADY), .S1_HREADYOUT(S1_HREADYOUT),
      .S1_HRESP(S1_HRESP), .S1_HRDATA(S1_HRDATA),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data)
   );

   always #5 HCLK = ~HCLK;

   function automatic logic [31:0] rom_fn(input logic [ADDR_W-1:0] a);
      if (a == 15'd4) return 32'hDEADBEEF;
      return 32'h5A00_0000 ^ {a, 2'b01, a};
   endfunction

   // ROM macro model: data appears the cycle after rom_en.
   always @(posedge HCLK) if (rom_en) rom_data <= rom_fn(rom_addr);

   typedef struct {
      logic        sel;
      logic [1:0]  tr;
      logic        wr;
      logic        lk;
      logic        rdy;
      logic [31:0] a;
   } pin_t;

   typedef struct {
      logic        en;
      logic [14:0] ra;
      logic        r0;
      logic [1:0]  rs0;
      logic        d0;
      logic        r1;
      logic [1:0]  rs1;
      logic        d1;
   } exp_t;

   typedef struct {
      logic rst;
      pin_t p0;
      pin_t p1;
      exp_t e;
   } vec_t;

   vec_t        tbl[$];
   logic [31:0] q0[$];
   logic [31:0] q1[$];

   function automatic pin_t pn(input logic [1:0] tr, input logic wr, input logic lk,
                               input logic rdy, input logic [31:0] a);
      pin_t p;
      p.sel = 1'b1; p.tr = tr; p.wr = wr; p.lk = lk; p.rdy = rdy; p.a = a;
      return p;
   endfunction

   function automatic pin_t idl();
      pin_t p;
      p.sel = 1'b0; p.tr = HTRANS_IDLE; p.wr = 1'b0; p.lk = 1'b0; p.rdy = 1'b1; p.a = '0;
      return p;
   endfunction

   function automatic pin_t rd(input logic [31:0] a);  return pn(HTRANS_NONSEQ, 1'b0, 1'b0, 1'b1, a); endfunction
   function automatic pin_t hd(input logic [31:0] a);  return pn(HTRANS_NONSEQ, 1'b0, 1'b0, 1'b0, a); endfunction
   function automatic pin_t lrd(input logic [1:0] tr, input logic [31:0] a); return pn(tr, 1'b0, 1'b1, 1'b1, a); endfunction

   function automatic exp_t ex(input logic en, input logic [14:0] ra,
                               input logic r0, input logic [1:0] rs0, input logic d0,
                               input logic r1, input logic [1:0] rs1, input logic d1);
      exp_t e;
      e.en = en; e.ra = ra; e.r0 = r0; e.rs0 = rs0; e.d0 = d0; e.r1 = r1; e.rs1 = rs1; e.d1 = d1;
      return e;
   endfunction

   function automatic vec_t vv(input logic rst, input pin_t p0, input pin_t p1, input exp_t e);
      vec_t v;
      v.rst = rst; v.p0 = p0; v.p1 = p1; v.e = e;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input int port, input pin_t p);
      if (port == 0) begin
         S0_HSEL = p.sel; S0_HTRANS = p.tr; S0_HWRITE = p.wr;
         S0_HMASTLOCK = p.lk; S0_HREADY = p.rdy; S0_HADDR = p.a;
      end else begin
         S1_HSEL = p.sel; S1_HTRANS = p.tr; S1_HWRITE = p.wr;
         S1_HMASTLOCK = p.lk; S1_HREADY = p.rdy; S1_HADDR = p.a;
      end
   endtask

   // Record the data a newly accepted read must eventually return.
   task automatic push_if(input int port, input pin_t p);
      logic [31:0] a;
      a = p.a;
      if (p.sel && p.tr[1] && p.rdy && !p.wr) begin
         if (port == 0) q0.push_back(rom_fn(a[ADDR_W+1:2]));
         else           q1.push_back(rom_fn(a[ADDR_W+1:2]));
      end
   endtask

   task automatic chk_data(input int port, input logic done, input logic [31:0] act, input string name);
      logic [31:0] e;
      if (!done) begin
         chk(name, act, 32'h0);
      end else if ((port == 0 && q0.size() == 0) || (port == 1 && q1.size() == 0)) begin
         checks++;
         errors++;
         $display("FAIL %s: got %h expected <no read outstanding>", name, act);
      end else begin
         e = (port == 0) ? q0.pop_front() : q1.pop_front();
         chk(name, act, e);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      @(posedge HCLK);
      #1;
      HRESET = v.rst;
      drive(0, v.p0);
      drive(1, v.p1);
      if (!v.rst) begin
         push_if(0, v.p0);
         push_if(1, v.p1);
      end
      @(negedge HCLK);
      chk($sformatf("v%0d rom_en", idx), 32'(rom_en), 32'(v.e.en));
      if (v.e.en) chk($sformatf("v%0d rom_addr", idx), 32'(rom_addr), 32'(v.e.ra));
      chk($sformatf("v%0d s0_hreadyout", idx), 32'(S0_HREADYOUT), 32'(v.e.r0));
      chk($sformatf("v%0d s0_hresp", idx), 32'(S0_HRESP), 32'(v.e.rs0));
      chk_data(0, v.e.d0, S0_HRDATA, $sformatf("v%0d s0_hrdata", idx));
      chk($sformatf("v%0d s1_hreadyout", idx), 32'(S1_HREADYOUT), 32'(v.e.r1));
      chk($sformatf("v%0d s1_hresp", idx), 32'(S1_HRESP), 32'(v.e.rs1));
      chk_data(1, v.e.d1, S1_HRDATA, $sformatf("v%0d s1_hrdata", idx));
      if (v.rst) begin
         q0.delete();
         q1.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n, low_cnt;
      logic        got;
      logic [31:0] base, b, a;

      HRESET = 1'b1;
      drive(0, idl());
      drive(1, idl());
      repeat (2) @(posedge HCLK);
      @(negedge HCLK);
      chk("rst s0_hreadyout", 32'(S0_HREADYOUT), 32'd1);
      chk("rst s1_hreadyout", 32'(S1_HREADYOUT), 32'd1);
      chk("rst s0_hresp", 32'(S0_HRESP), 32'd0);
      chk("rst s1_hresp", 32'(S1_HRESP), 32'd0);
      chk("rst s0_hrdata", S0_HRDATA, 32'd0);
      chk("rst s1_hrdata", S1_HRDATA, 32'd0);
      chk("rst rom_en", 32'(rom_en), 32'd0);
      chk("rst rom_addr", 32'(rom_addr), 32'd0);

      // rst, S0 pins, S1 pins, {rom_en, rom_addr, S0 rdy/resp/done, S1 rdy/resp/done}
      tbl.push_back(vv(0, rd(32'h0),  rd(32'h4),  ex(1, 0,  1,0,0, 1,0,0)));
      tbl.push_back(vv(0, idl(),      hd(32'h4),  ex(1, 1,  1,0,1, 0,0,0)));
      tbl.push_back(vv(0, idl(),      idl(),      ex(0, 0,  1,0,0, 1,0,1)));
      tbl.push_back(vv(0, rd(32'h10), idl(),      ex(1, 4,  1,0,0, 1,0,0)));
      tbl.push_back(vv(0, idl(),      idl(),      ex(0, 0,  1,0,1, 1,0,0)));
      tbl.push_back(vv(0, rd(32'h20), rd(32'h24), ex(1, 9,  1,0,0, 1,0,0)));
      tbl.push_back(vv(0, hd(32'h20), rd(32'h28), ex(1, 8,  0,0,0, 1,0,1)));
      tbl.push_back(vv(0, rd(32'h2C), hd(32'h28), ex(1, 10, 1,0,1, 0,0,0)));
      tbl.push_back(vv(0, hd(32'h2C), rd(32'h30), ex(1, 11, 0,0,0, 1,0,1)));
      tbl.push_back(vv(0, idl(),      hd(32'h30), ex(1, 12, 1,0,1, 0,0,0)));
      tbl.push_back(vv(0, idl(),      idl(),      ex(0, 0,  1,0,0, 1,0,1)));
      tbl.push_back(vv(0, lrd(HTRANS_NONSEQ, 32'h40), rd(32'h50), ex(1, 16, 1,0,0, 1,0,0)));
      tbl.push_back(vv(0, lrd(HTRANS_SEQ, 32'h44), hd(32'h50), ex(1, 17, 1,0,1, 0,0,0)));
      tbl.push_back(vv(0, lrd(HTRANS_SEQ, 32'h48), hd(32'h50), ex(1, 18, 1,0,1, 0,0,0)));
      tbl.push_back(vv(0, lrd(HTRANS_SEQ, 32'h4C), hd(32'h50), ex(1, 19, 1,0,1, 0,0,0)));
      tbl.push_back(vv(0, idl(),      hd(32'h50), ex(1, 20, 1,0,1, 0,0,0)));
      tbl.push_back(vv(0, idl(),      idl(),      ex(0, 0,  1,0,0, 1,0,1)));
      tbl.push_back(vv(0, idl(), pn(HTRANS_NONSEQ, 1, 0, 1, 32'h8), ex(0, 0, 1,0,0, 1,0,0)));
      tbl.push_back(vv(0, idl(),      idl(),      ex(0, 0,  1,0,0, 0,1,0)));
      tbl.push_back(vv(0, idl(),      idl(),      ex(0, 0,  1,0,0, 1,1,0)));
      tbl.push_back(vv(0, idl(),      idl(),      ex(0, 0,  1,0,0, 1,0,0)));
      tbl.push_back(vv(0, pn(HTRANS_BUSY, 0, 0, 1, 32'h10), idl(), ex(0, 0, 1,0,0, 1,0,0)));
      tbl.push_back(vv(0, idl(),      idl(),      ex(0, 0,  1,0,0, 1,0,0)));
      tbl.push_back(vv(0, rd(32'hFFFE_0010), idl(), ex(1, 4, 1,0,0, 1,0,0)));
      tbl.push_back(vv(0, idl(),      idl(),      ex(0, 0,  1,0,1, 1,0,0)));
      tbl.push_back(vv(0, idl(),      rd(32'h8),  ex(1, 2,  1,0,0, 1,0,0)));
      tbl.push_back(vv(0, idl(),      idl(),      ex(0, 0,  1,0,0, 1,0,1)));
      tbl.push_back(vv(0, rd(32'h0),  rd(32'h4),  ex(1, 0,  1,0,0, 1,0,0)));
      tbl.push_back(vv(1, idl(),      hd(32'h4),  ex(0, 0,  1,0,1, 0,0,0)));
      tbl.push_back(vv(0, idl(),      idl(),      ex(0, 0,  1,0,0, 1,0,0)));
      tbl.push_back(vv(0, rd(32'h0),  rd(32'h4),  ex(1, 0,  1,0,0, 1,0,0)));
      tbl.push_back(vv(0, idl(),      hd(32'h4),  ex(1, 1,  1,0,1, 0,0,0)));
      tbl.push_back(vv(0, idl(),      idl(),      ex(0, 0,  1,0,0, 1,0,1)));

      foreach (tbl[i]) run_vec(tbl[i], i);

      // Random-length locked S0 burst while S1 waits; S1 must follow right after.
      n       = int'($urandom_range(2, 5));
      base    = 32'($urandom_range(8, 4000)) << 2;
      b       = 32'($urandom_range(0, 32767)) << 2;
      low_cnt = 0;
      @(posedge HCLK);
      #1;
      drive(0, lrd(HTRANS_NONSEQ, base));
      drive(1, rd(b));
      push_if(0, lrd(HTRANS_NONSEQ, base));
      push_if(1, rd(b));
      @(negedge HCLK);
      chk("lock beat0 rom_en", 32'(rom_en), 32'd1);
      chk("lock beat0 rom_addr", 32'(rom_addr), 32'(base[ADDR_W+1:2]));
      for (int k = 1; k <= n; k++) begin
         a = base + 32'(4 * k);
         @(posedge HCLK);
         #1;
         if (k < n) begin
            drive(0, lrd(HTRANS_SEQ, a));
            push_if(0, lrd(HTRANS_SEQ, a));
         end else begin
            drive(0, idl());
         end
         drive(1, hd(b));
         @(negedge HCLK);
         chk($sformatf("lock beat%0d s0_hreadyout", k), 32'(S0_HREADYOUT), 32'd1);
         chk_data(0, 1'b1, S0_HRDATA, $sformatf("lock beat%0d s0_hrdata", k));
         chk($sformatf("lock beat%0d rom_addr", k), 32'(rom_addr),
             (k < n) ? 32'(a[ADDR_W+1:2]) : 32'(b[ADDR_W+1:2]));
         if (!S1_HREADYOUT) low_cnt++;
      end
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
         @(posedge HCLK);
         #1;
         drive(0, idl());
         drive(1, hd(b));
         @(negedge HCLK);
         if (S1_HREADYOUT) begin
            got = 1'b1;
            chk_data(1, 1'b1, S1_HRDATA, "lock s1_hrdata");
         end else begin
            low_cnt++;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL lock s1 timeout: S1_HREADYOUT still %b after budget, required 1", S1_HREADYOUT);
      end
      chk("lock s1 wait cycles", 32'(low_cnt), 32'(n));
      @(posedge HCLK);
      #1;
      drive(1, idl());
      @(negedge HCLK);

      chk("s0 scoreboard empty", 32'(q0.size()), 32'd0);
      chk("s1 scoreboard empty", 32'(q1.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
